// File: rtl/mii_rx_nibble_packer.sv
// -----------------------------------------------------------------------------
// mii_rx_nibble_packer
//
// Packs registered MII receive nibbles into bytes. Preamble nibbles (0x5) are
// counted and stripped. The SFD nibble (0xD) is accepted only after at least
// MIN_PREAMBLE_NIBBLES preamble nibbles. After that, nibbles are paired low
// first into {high, low} bytes. Frames that start badly are dropped silently
// until mii_rx_dv falls.
//
// Optional feature macro: MII_RX_PACKER_STATS_EN adds three wrapping 16-bit
// counters: frames ended, frames dropped and frames ending on an odd nibble.
//
// Ports
//   clk          RX clock (capture stage output clock)
//   rst_n        synchronous reset, active-low
//   mii_rxd      registered MII data nibble
//   mii_rx_dv    registered MII data valid
//   mii_rx_er    registered MII receive error
//   m_data       assembled byte {high nibble, low nibble}, held between bytes
//   m_valid      one-cycle strobe qualifying m_data/m_start/m_err
//   m_start      first byte after SFD
//   m_err        rx_er seen on either nibble of this byte
//   m_end        one-cycle end-of-frame pulse, never together with m_valid
//   m_odd        with m_end: frame ended on an unpaired nibble
//   stat_frames  (stats build) +1 per m_end
//   stat_drops   (stats build) +1 per entry into DROP
//   stat_odd     (stats build) +1 per m_odd
// -----------------------------------------------------------------------------
// state     | meaning
// ----------+------------------------------------------------------------------
// IDLE      | waiting for dv; the first nibble decides preamble or drop
// PREAMBLE  | counting 0x5 nibbles, waiting for the SFD
// DATA_LO   | next nibble is the low half of a byte
// DATA_HI   | next nibble is the high half of a byte; the byte is emitted then
// DROP      | frame rejected, wait for dv low
// -----------------------------------------------------------------------------
module mii_rx_nibble_packer #(
    parameter int unsigned MIN_PREAMBLE_NIBBLES = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mii_rxd,
    input  logic        mii_rx_dv,
    input  logic        mii_rx_er,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_start,
    output logic        m_err,
    output logic        m_end,
    output logic        m_odd
`ifdef MII_RX_PACKER_STATS_EN
    ,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_drops,
    output logic [15:0] stat_odd
`endif
);

    localparam logic [3:0] NIB_PRE = 4'h5;
    localparam logic [3:0] NIB_SFD = 4'hD;
    localparam logic [3:0] MIN_CNT = 4'(MIN_PREAMBLE_NIBBLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_DROP
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] pre_cnt, pre_cnt_nxt;
    logic [3:0] lo_nib, lo_nib_nxt;
    logic       er_lo, er_lo_nxt;
    logic       first_byte, first_byte_nxt;
    logic       byte_seen, byte_seen_nxt;

    logic [7:0] data_nxt;
    logic       valid_nxt, start_nxt, err_nxt, end_nxt, odd_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pre_cnt    <= 4'd0;
            lo_nib     <= 4'd0;
            er_lo      <= 1'b0;
            first_byte <= 1'b0;
            byte_seen  <= 1'b0;
            m_data     <= 8'd0;
            m_valid    <= 1'b0;
            m_start    <= 1'b0;
            m_err      <= 1'b0;
            m_end      <= 1'b0;
            m_odd      <= 1'b0;
        end else begin
            state      <= state_nxt;
            pre_cnt    <= pre_cnt_nxt;
            lo_nib     <= lo_nib_nxt;
            er_lo      <= er_lo_nxt;
            first_byte <= first_byte_nxt;
            byte_seen  <= byte_seen_nxt;
            m_data     <= data_nxt;
            m_valid    <= valid_nxt;
            m_start    <= start_nxt;
            m_err      <= err_nxt;
            m_end      <= end_nxt;
            m_odd      <= odd_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pre_cnt_nxt    = pre_cnt;
        lo_nib_nxt     = lo_nib;
        er_lo_nxt      = er_lo;
        first_byte_nxt = first_byte;
        byte_seen_nxt  = byte_seen;
        data_nxt       = m_data;
        valid_nxt      = 1'b0;
        start_nxt      = 1'b0;
        err_nxt        = 1'b0;
        end_nxt        = 1'b0;
        odd_nxt        = 1'b0;

        case (state)
            ST_IDLE: begin
                // rx_er without dv is carrier-extension/false-carrier noise here
                if (mii_rx_dv) begin
                    if (mii_rxd == NIB_PRE) begin
                        state_nxt   = ST_PREAMBLE;
                        pre_cnt_nxt = 4'd1;
                    end else begin
                        state_nxt = ST_DROP;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!mii_rx_dv) begin
                    state_nxt = ST_IDLE;
                end else if (mii_rxd == NIB_PRE) begin
                    if (pre_cnt != 4'hF) pre_cnt_nxt = pre_cnt + 4'd1;
                end else if (mii_rxd == NIB_SFD && pre_cnt >= MIN_CNT) begin
                    state_nxt      = ST_DATA_LO;
                    first_byte_nxt = 1'b1;
                    byte_seen_nxt  = 1'b0;
                end else begin
                    state_nxt = ST_DROP;
                end
            end

            ST_DATA_LO: begin
                if (mii_rx_dv) begin
                    lo_nib_nxt = mii_rxd;
                    er_lo_nxt  = mii_rx_er;
                    state_nxt  = ST_DATA_HI;
                end else begin
                    // an SFD followed directly by dv low is not reported
                    state_nxt = ST_IDLE;
                    end_nxt   = byte_seen;
                end
            end

            ST_DATA_HI: begin
                if (mii_rx_dv) begin
                    data_nxt       = {mii_rxd, lo_nib};
                    valid_nxt      = 1'b1;
                    err_nxt        = er_lo | mii_rx_er;
                    start_nxt      = first_byte;
                    first_byte_nxt = 1'b0;
                    byte_seen_nxt  = 1'b1;
                    state_nxt      = ST_DATA_LO;
                end else begin
                    // a dangling nibble still counts as a seen frame
                    state_nxt = ST_IDLE;
                    end_nxt   = 1'b1;
                    odd_nxt   = 1'b1;
                end
            end

            ST_DROP: begin
                if (!mii_rx_dv) state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef MII_RX_PACKER_STATS_EN
    logic drop_evt;
    assign drop_evt = (state_nxt == ST_DROP) && (state != ST_DROP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_frames <= 16'd0;
            stat_drops  <= 16'd0;
            stat_odd    <= 16'd0;
        end else begin
            if (end_nxt)  stat_frames <= stat_frames + 16'd1;
            if (drop_evt) stat_drops  <= stat_drops + 16'd1;
            if (odd_nxt)  stat_odd    <= stat_odd + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mii_rx_nibble_packer.sv
module tb_mii_rx_nibble_packer;

    localparam int MIN = 7;
    localparam int N   = 700;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] mii_rxd = 4'd0;
    logic       mii_rx_dv = 1'b0;
    logic       mii_rx_er = 1'b0;
    logic [7:0] m_data;
    logic       m_valid, m_start, m_err, m_end, m_odd;
`ifdef MII_RX_PACKER_STATS_EN
    logic [15:0] stat_frames, stat_drops, stat_odd;
`endif

    always #5 clk = ~clk;

    mii_rx_nibble_packer #(.MIN_PREAMBLE_NIBBLES(MIN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mii_rxd    (mii_rxd),
        .mii_rx_dv  (mii_rx_dv),
        .mii_rx_er  (mii_rx_er),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_start    (m_start),
        .m_err      (m_err),
        .m_end      (m_end),
        .m_odd      (m_odd)
`ifdef MII_RX_PACKER_STATS_EN
        ,
        .stat_frames(stat_frames),
        .stat_drops (stat_drops),
        .stat_odd   (stat_odd)
`endif
    );

    // stimulus, one entry per sampling edge
    logic       s_rst [N];
    logic       s_dv  [N];
    logic [3:0] s_rxd [N];
    logic       s_er  [N];
    int         ns = 0;

    // model events and per-edge expected outputs
    logic       ev_valid [N];
    logic [7:0] ev_data  [N];
    logic       ev_start [N];
    logic       ev_err   [N];
    logic       ev_end   [N];
    logic       ev_odd   [N];
    logic       ev_drop  [N];

    logic [7:0]  x_data   [N];
    logic        x_valid  [N];
    logic        x_start  [N];
    logic        x_err    [N];
    logic        x_end    [N];
    logic        x_odd    [N];
    logic [15:0] x_frames [N];
    logic [15:0] x_drops  [N];
    logic [15:0] x_odds   [N];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int t, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, t, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic dv, input logic [3:0] d, input logic er);
        s_rst[ns] = r; s_dv[ns] = dv; s_rxd[ns] = d; s_er[ns] = er;
        ns++;
    endtask

    task automatic idle(input int n, input logic er);
        for (int i = 0; i < n; i++) add(1'b1, 1'b0, 4'h0, er);
    endtask

    task automatic pre_sfd(input int n);
        for (int i = 0; i < n; i++) add(1'b1, 1'b1, 4'h5, 1'b0);
        add(1'b1, 1'b1, 4'hD, 1'b0);
    endtask

    task automatic nib(input logic [3:0] d, input logic er);
        add(1'b1, 1'b1, d, er);
    endtask

    // Frame-level model: each dv burst is classified from its nibble list,
    // then bytes/end marks are placed at the edge sampling the deciding nibble.
    task automatic run_model();
        int t, s, l, e, p, nd, base, c;
        logic aborted;
        logic [7:0] last;
        logic [15:0] fr, dr, od;
        for (int i = 0; i < N; i++) begin
            ev_valid[i] = 0; ev_data[i] = 0; ev_start[i] = 0; ev_err[i] = 0;
            ev_end[i] = 0; ev_odd[i] = 0; ev_drop[i] = 0;
        end
        t = 0;
        while (t < ns) begin
            if (!s_rst[t] || !s_dv[t]) begin
                t++;
            end else begin
                s = t; l = 0;
                while (t < ns && s_rst[t] && s_dv[t]) begin t++; l++; end
                e = t;
                aborted = (e < ns) && !s_rst[e];
                p = 0;
                while (p < l && s_rxd[s+p] == 4'h5) p++;
                if (p == l) begin
                    // preamble only: silently forgotten
                end else if (p == 0 || s_rxd[s+p] != 4'hD || p < MIN) begin
                    ev_drop[s+p] = 1;
                end else begin
                    nd = l - p - 1;
                    base = s + p + 1;
                    for (int j = 0; 2*j + 1 < nd; j++) begin
                        c = base + 2*j + 1;
                        ev_valid[c] = 1;
                        ev_data[c]  = {s_rxd[c], s_rxd[c-1]};
                        ev_err[c]   = s_er[c] | s_er[c-1];
                        ev_start[c] = (j == 0);
                    end
                    if (!aborted && e < N) begin
                        if (nd % 2 == 1) begin ev_end[e] = 1; ev_odd[e] = 1; end
                        else if (nd >= 2) ev_end[e] = 1;
                    end
                end
            end
        end
        last = 0; fr = 0; dr = 0; od = 0;
        for (int i = 0; i < ns; i++) begin
            if (!s_rst[i]) begin
                last = 0; fr = 0; dr = 0; od = 0;
                x_valid[i] = 0; x_start[i] = 0; x_err[i] = 0; x_end[i] = 0; x_odd[i] = 0;
            end else begin
                if (ev_valid[i]) last = ev_data[i];
                fr += 16'(ev_end[i]); dr += 16'(ev_drop[i]); od += 16'(ev_odd[i]);
                x_valid[i] = ev_valid[i]; x_start[i] = ev_start[i]; x_err[i] = ev_err[i];
                x_end[i] = ev_end[i]; x_odd[i] = ev_odd[i];
            end
            x_data[i] = last; x_frames[i] = fr; x_drops[i] = dr; x_odds[i] = od;
        end
    endtask

    int s1, s2, s3, s4, s5, s6, cnt;

    initial begin
        add(1'b0, 1'b0, 4'h0, 1'b0);
        add(1'b0, 1'b0, 4'h0, 1'b0);
        idle(3, 1'b1);                       // rx_er without dv is ignored
        // long preamble (saturating count), four bytes
        s1 = ns; pre_sfd(15);
        nib(2,0); nib(1,0); nib(4,0); nib(3,0); nib(6,0); nib(5,0); nib(8,0); nib(7,0);
        idle(2, 1'b0);
        // short preamble -> drop
        s2 = ns; pre_sfd(3); nib(1,0); nib(2,0); nib(3,0); nib(4,0);
        idle(2, 1'b0);
        // MIN-1 preamble -> drop
        pre_sfd(MIN-1); nib(1,0); nib(2,0); idle(2, 1'b0);
        // exactly MIN preamble, odd nibble count
        s3 = ns; pre_sfd(MIN); nib(1,0); nib(0,0); nib(2,0); nib(0,0); nib(3,0);
        idle(2, 1'b0);
        // rx_er on low nibble of byte 2
        s4 = ns; pre_sfd(MIN); nib(1,0); nib(2,0); nib(3,1); nib(4,0); nib(5,0); nib(6,0);
        idle(2, 1'b0);
        // reset while in DATA_HI, dv held, then an intact frame
        s5 = ns; pre_sfd(MIN); nib(1,0); nib(2,0); nib(3,0);
        add(1'b0, 1'b1, 4'h4, 1'b0);
        nib(6,0); nib(7,0); nib(8,0);
        idle(1, 1'b0);
        pre_sfd(8); nib(4'hA,0); nib(4'hB,0); nib(4'hC,0); nib(4'hD,0);
        idle(2, 1'b0);
        // back-to-back frames with one dv-low gap
        s6 = ns; pre_sfd(MIN); nib(1,0); nib(2,0); idle(1, 1'b0);
        pre_sfd(MIN); nib(3,0); nib(4,0); nib(5,0); nib(6,0); idle(2, 1'b0);
        // zero-byte frame, single-nibble frame, preamble-only, non-5 start
        pre_sfd(MIN); idle(2, 1'b0);
        pre_sfd(MIN); nib(9,1); idle(2, 1'b0);
        for (int i = 0; i < 5; i++) nib(5,0);
        idle(2, 1'b0);
        nib(4'hD,0); nib(5,0); nib(4'hD,0); nib(1,0); idle(2, 1'b0);
        // short frame then reset with dv low
        pre_sfd(MIN); nib(7,0); nib(8,0); add(1'b0, 1'b0, 4'h0, 1'b0);
        idle(4, 1'b0);

        run_model();

        // hand-computed pins on the model
        chk("pin_b0_valid", s1+17, 16'(x_valid[s1+17]), 16'd1);
        chk("pin_b0_data",  s1+17, 16'(x_data[s1+17]), 16'h12);
        chk("pin_b0_start", s1+17, 16'(x_start[s1+17]), 16'd1);
        chk("pin_b1_data",  s1+19, 16'(x_data[s1+19]), 16'h34);
        chk("pin_b1_start", s1+19, 16'(x_start[s1+19]), 16'd0);
        chk("pin_b3_data",  s1+23, 16'(x_data[s1+23]), 16'h78);
        chk("pin_end",      s1+24, 16'(x_end[s1+24]), 16'd1);
        chk("pin_end_odd",  s1+24, 16'(x_odd[s1+24]), 16'd0);
        cnt = 0;
        for (int i = s2; i < s2 + 10; i++) cnt += int'(x_valid[i]) + int'(x_end[i]);
        chk("pin_short_pre_silent", s2, 16'(cnt), 16'd0);
        chk("pin_odd_b0",   s3+9,  16'(x_data[s3+9]), 16'h01);
        chk("pin_odd_b1",   s3+11, 16'(x_data[s3+11]), 16'h02);
        chk("pin_odd_end",  s3+13, 16'({x_end[s3+13], x_odd[s3+13]}), 16'b11);
        chk("pin_err_b1",   s4+9,  16'({x_valid[s4+9], x_err[s4+9]}), 16'b10);
        chk("pin_err_b2",   s4+11, 16'({x_valid[s4+11], x_err[s4+11]}), 16'b11);
        chk("pin_err_b3",   s4+13, 16'({x_valid[s4+13], x_err[s4+13]}), 16'b10);
        chk("pin_rst_zero", s5+11, 16'({x_data[s5+11], x_end[s5+11]}), 16'd0);
        chk("pin_b2b_end1", s6+10, 16'(x_end[s6+10]), 16'd1);
        chk("pin_b2b_st2",  s6+20, 16'(x_start[s6+20]), 16'd1);

        fork
            begin
                rst_n = s_rst[0]; mii_rx_dv = s_dv[0]; mii_rxd = s_rxd[0]; mii_rx_er = s_er[0];
                for (int t = 1; t < ns; t++) begin
                    @(posedge clk);
                    #1;
                    rst_n = s_rst[t]; mii_rx_dv = s_dv[t]; mii_rxd = s_rxd[t]; mii_rx_er = s_er[t];
                end
            end
            begin
                for (int k = 0; k < ns; k++) begin
                    @(posedge clk);
                    #2;
                    chk("m_valid", k, 16'(m_valid), 16'(x_valid[k]));
                    chk("m_data",  k, 16'(m_data),  16'(x_data[k]));
                    chk("m_start", k, 16'(m_start), 16'(x_start[k]));
                    chk("m_err",   k, 16'(m_err),   16'(x_err[k]));
                    chk("m_end",   k, 16'(m_end),   16'(x_end[k]));
                    chk("m_odd",   k, 16'(m_odd),   16'(x_odd[k]));
`ifdef MII_RX_PACKER_STATS_EN
                    chk("stat_frames", k, stat_frames, x_frames[k]);
                    chk("stat_drops",  k, stat_drops,  x_drops[k]);
                    chk("stat_odd",    k, stat_odd,    x_odds[k]);
`endif
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
